// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, debug-loadable word-addressed instruction
// memory, and the IF/ID pipeline register that feeds decode.
module instruction_fetch #(
  parameter int          IMEM_DEPTH  = 256,
  parameter int          IMEM_ADDR_W = 8,
  parameter logic [31:0] HALT_WORD   = 32'hffffffff
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_jump,
  input  logic [31:0] i_jump_addr,
  input  logic        i_imem_wr_en,
  input  logic [31:0] i_imem_wr_addr,
  input  logic [31:0] i_imem_wr_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_instruction
);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_p0;
  logic [31:0] pc4_p1;
  logic [31:0] instr_p1;

  logic [31:0] fetch_word;
  logic [31:0] pc_nxt;
  logic [31:0] pc4_nxt;
  logic [31:0] instr_nxt;
  logic        advance;
  logic        fetch_in_range;
  logic        wr_in_range;
  logic [1:0]  unused_wr_lsb;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign unused_wr_lsb = i_imem_wr_addr[1:0];

  // Stage p0: PC and combinational fetch; out-of-range PCs read as the halt word
  assign fetch_in_range = (pc_p0[31:IMEM_ADDR_W+2] == '0);
  assign fetch_word     = fetch_in_range ? imem[pc_p0[IMEM_ADDR_W+1:2]] : HALT_WORD;
  assign wr_in_range    = (i_imem_wr_addr[31:IMEM_ADDR_W+2] == '0);

  // Stall outranks jump: a branch resolved against stale operands must not redirect
  assign advance = i_enable & ~i_halt & ~i_stall;

  always_comb begin
    pc_nxt    = pc_p0;
    pc4_nxt   = pc4_p1;
    instr_nxt = instr_p1;
    if (advance) begin
      if (i_jump) begin
        pc_nxt    = i_jump_addr;
        pc4_nxt   = '0;
        instr_nxt = '0;
      end else begin
        pc_nxt    = pc_incr(pc_p0);
        pc4_nxt   = pc_incr(pc_p0);
        instr_nxt = fetch_word;
      end
    end
  end

  // Stage p1: IF/ID register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_p0    <= '0;
      pc4_p1   <= '0;
      instr_p1 <= '0;
    end else begin
      pc_p0    <= pc_nxt;
      pc4_p1   <= pc4_nxt;
      instr_p1 <= instr_nxt;
    end
  end

  // Debug loads bypass enable/stall/halt and survive reset
  always_ff @(posedge i_clk) begin
    if (i_imem_wr_en && wr_in_range) begin
      imem[i_imem_wr_addr[IMEM_ADDR_W+1:2]] <= i_imem_wr_data;
    end
  end

  assign o_pc          = pc_p0;
  assign o_pc4         = pc4_p1;
  assign o_instruction = instr_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run compared against a behavioural model of the stage.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hffffffff;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_stall, i_halt, i_jump, i_imem_wr_en;
  logic [31:0] i_jump_addr, i_imem_wr_addr, i_imem_wr_data;
  logic [31:0] o_pc, o_pc4, o_instruction;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_pc4, m_instr;

  instruction_fetch dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_stall        (i_stall),
    .i_halt         (i_halt),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .i_imem_wr_en   (i_imem_wr_en),
    .i_imem_wr_addr (i_imem_wr_addr),
    .i_imem_wr_data (i_imem_wr_data),
    .o_pc           (o_pc),
    .o_pc4          (o_pc4),
    .o_instruction  (o_instruction)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [31:0] m_fetch(input logic [31:0] addr);
    if (addr >= 32'h400) return HALT;
    return m_mem[addr / 4];
  endfunction

  // One clock edge; the model applies the stage's priority rules to the inputs held across it.
  task automatic cycle();
    logic [31:0] n_pc, n_pc4, n_instr;
    n_pc = m_pc; n_pc4 = m_pc4; n_instr = m_instr;
    if (!i_enable || i_halt || i_stall) begin
      // frozen
    end else if (i_jump) begin
      n_pc = i_jump_addr; n_pc4 = 0; n_instr = 0;
    end else begin
      n_instr = m_fetch(m_pc); n_pc4 = m_pc + 4; n_pc = m_pc + 4;
    end
    @(posedge i_clk);
    if (i_imem_wr_en && i_imem_wr_addr < 32'h400) m_mem[i_imem_wr_addr / 4] = i_imem_wr_data;
    m_pc = n_pc; m_pc4 = n_pc4; m_instr = n_instr;
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    m_pc = 0; m_pc4 = 0; m_instr = 0;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [95:0] act, exp;
    exp = '0;
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL reset_state: got %h required %h", act, exp); end
    // Load all memory with enable low; the stage must stay frozen at zero.
    i_reset = 1'b0;
    i_enable = 1'b0;
    i_imem_wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      i_imem_wr_addr = i * 4;
      i_imem_wr_data = $urandom & 32'h7fffffff;
      cycle();
    end
    i_imem_wr_addr = 32'h0;  i_imem_wr_data = 32'h20010005; cycle();
    i_imem_wr_addr = 32'h4;  i_imem_wr_data = 32'h20020007; cycle();
    i_imem_wr_addr = 32'h8;  i_imem_wr_data = 32'h00221820; cycle();
    i_imem_wr_addr = 32'hc;  i_imem_wr_data = 32'hffffffff; cycle();
    i_imem_wr_addr = 32'h14; i_imem_wr_data = 32'h11111111; cycle();
    i_imem_wr_en = 1'b0;
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL frozen_during_load: got %h required %h", act, exp); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    logic [95:0] act, exp;
    words[0] = 32'h20010005; words[1] = 32'h20020007; words[2] = 32'h00221820; words[3] = 32'hffffffff;
    do_reset();
    i_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp = {32'(4 * (i + 1)), 32'(4 * (i + 1)), words[i]};
      act = {o_pc, o_pc4, o_instruction};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL seq_fetch_%0d: got %h required %h", i, act, exp); end
    end
    i_halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp = {32'd16, 32'd16, 32'hffffffff};
      act = {o_pc, o_pc4, o_instruction};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL halt_freeze_%0d: got %h required %h", i, act, exp); end
    end
    i_halt = 1'b0;
  endtask

  task automatic test_jump();
    logic [95:0] act, exp;
    do_reset();
    i_enable = 1'b1;
    cycle(); cycle();
    i_jump = 1'b1; i_jump_addr = 32'h40;
    cycle();
    i_jump = 1'b0;
    exp = {32'h40, 32'h0, 32'h0};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL jump_flush: got %h required %h", act, exp); end
    cycle();
    exp = {32'h44, 32'h44, m_mem[16]};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL jump_target: got %h required %h", act, exp); end
  endtask

  task automatic test_stall_jump();
    logic [95:0] act, exp;
    do_reset();
    i_enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp = {32'h10, 32'h10, 32'hffffffff};
      act = {o_pc, o_pc4, o_instruction};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL stall_over_jump_%0d: got %h required %h", i, act, exp); end
    end
    i_stall = 1'b0;
    cycle();
    i_jump = 1'b0;
    exp = {32'h80, 32'h0, 32'h0};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL jump_after_stall: got %h required %h", act, exp); end
  endtask

  task automatic test_debug_load();
    logic [95:0] act, exp;
    do_reset();
    i_enable = 1'b1;
    cycle();
    i_enable = 1'b0;
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 32'h14; i_imem_wr_data = 32'h8c220004;
    cycle();
    i_imem_wr_en = 1'b0;
    exp = {32'h4, 32'h4, 32'h20010005};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL debug_freeze: got %h required %h", act, exp); end
    i_enable = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    exp = {32'h18, 32'h18, 32'h8c220004};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL debug_loaded_word: got %h required %h", act, exp); end
  endtask

  task automatic test_out_of_range();
    logic [95:0] act, exp;
    i_enable = 1'b1;
    i_jump = 1'b1; i_jump_addr = 32'h400;
    cycle();
    i_jump = 1'b0;
    cycle();
    exp = {32'h404, 32'h404, HALT};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL oor_fetch: got %h required %h", act, exp); end
    i_jump = 1'b1; i_jump_addr = 32'hfffffffc;
    cycle();
    i_jump = 1'b0;
    exp = {32'hfffffffc, 32'h0, 32'h0};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL wrap_jump: got %h required %h", act, exp); end
    cycle();
    exp = {32'h0, 32'h0, HALT};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL pc_wrap: got %h required %h", act, exp); end
    // An out-of-range write must not alias onto word 0.
    i_enable = 1'b0;
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 32'h400; i_imem_wr_data = 32'h12345678;
    cycle();
    i_imem_wr_en = 1'b0;
  endtask

  task automatic test_write_collision();
    logic [95:0] act, exp;
    do_reset();
    i_enable = 1'b1;
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 32'h0; i_imem_wr_data = 32'hdeadbeef;
    cycle();
    i_imem_wr_en = 1'b0;
    exp = {32'h4, 32'h4, 32'h20010005};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL collision_old_word: got %h required %h", act, exp); end
    do_reset();
    cycle();
    exp = {32'h4, 32'h4, 32'hdeadbeef};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL collision_new_word: got %h required %h", act, exp); end
    i_enable = 1'b0;
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 32'h0; i_imem_wr_data = 32'h20010005;
    cycle();
    i_imem_wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [95:0] act, exp;
    do_reset();
    i_enable = 1'b1;
    for (int i = 0; i < 9; i++) cycle();
    checks++;
    if (o_pc !== 32'h24) begin errors++; $display("FAIL pc_before_reset: got %h required %h", o_pc, 32'h24); end
    #2;
    i_reset = 1'b1;
    #1;
    exp = '0;
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL async_reset: got %h required %h", act, exp); end
    m_pc = 0; m_pc4 = 0; m_instr = 0;
    i_reset = 1'b0;
    cycle();
    exp = {32'h4, 32'h4, 32'h20010005};
    act = {o_pc, o_pc4, o_instruction};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL mem_kept_after_reset: got %h required %h", act, exp); end
  endtask

  task automatic test_random();
    logic [95:0] act, exp;
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_enable = ($urandom_range(0, 9) != 0);
      i_stall  = ($urandom_range(0, 3) == 0);
      i_halt   = ($urandom_range(0, 9) == 0);
      i_jump   = ($urandom_range(0, 6) == 0);
      r = $urandom_range(0, 9);
      if (r < 8)       i_jump_addr = $urandom_range(0, 1023);
      else if (r == 8) i_jump_addr = 32'h400 + $urandom_range(0, 255);
      else             i_jump_addr = $urandom;
      i_imem_wr_en   = ($urandom_range(0, 4) == 0);
      i_imem_wr_addr = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023);
      i_imem_wr_data = $urandom;
      cycle();
      exp = {m_pc, m_pc4, m_instr};
      act = {o_pc, o_pc4, o_instruction};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL random_%0d: got %h required %h", i, act, exp); end
    end
    i_enable = 1'b0; i_stall = 1'b0; i_halt = 1'b0; i_jump = 1'b0; i_imem_wr_en = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_halt = 1'b0; i_jump = 1'b0;
    i_jump_addr = '0; i_imem_wr_en = 1'b0; i_imem_wr_addr = '0; i_imem_wr_data = '0;
    m_pc = 0; m_pc4 = 0; m_instr = 0;
    #3;
    test_reset();
    test_sequential();
    test_jump();
    test_stall_jump();
    test_debug_load();
    test_out_of_range();
    test_write_collision();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
